// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types.
// Also defines the writeback-stage end-of-program state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic [1:0] {
        WB_RUN,
        WB_FLUSH,
        WB_HALTED
    } wb_state_t;

endpackage

// File: rtl/wb_data_select.sv
// Final register-file write data selection.
// Upper-immediate data has priority over load data; the ALU result is the default.
module wb_data_select #(
    parameter int unsigned WORD_W = 32
) (
    input  logic              lui_flag,
    input  logic              mem_to_reg,
    input  logic [WORD_W-1:0] alu_result,
    input  logic [WORD_W-1:0] load_data,
    input  logic [WORD_W-1:0] lui_data,
    output logic [WORD_W-1:0] wdat
);

    always_comb begin
        wdat = alu_result;
        if (lui_flag) begin
            wdat = lui_data;
        end else if (mem_to_reg) begin
            wdat = load_data;
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: drives the register file write port and a one-entry forwarding bypass.
// Sequences halt -> dcache flush -> system halt, and counts retired instructions.
module writeback_unit
    import cpu_types_pkg::*;
#(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned REG_SEL_W = 5,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 wbcuHALT,
    input  logic                 wbMemToReg,
    input  logic                 wbWEN,
    input  logic                 wbLUIflag,
    input  logic [REG_SEL_W-1:0] wbwsel,
    input  logic [WORD_W-1:0]    wbOutput_Port,
    input  logic [WORD_W-1:0]    wbdmemload,
    input  logic [WORD_W-1:0]    wbLUIdata,
    input  logic [WORD_W-1:0]    wbinstr,
    input  logic                 dflushed,
    output logic                 rf_WEN,
    output logic [REG_SEL_W-1:0] rf_wsel,
    output logic [WORD_W-1:0]    rf_wdat,
    output logic                 fwd_valid,
    output logic [REG_SEL_W-1:0] fwd_wsel,
    output logic [WORD_W-1:0]    fwd_wdat,
    output logic                 dflush,
    output logic                 halt,
    output logic [CNT_W-1:0]     retired
);

    wb_state_t         state;
    wb_state_t         state_next;
    logic              valid;
    logic              commit;
    logic [WORD_W-1:0] sel_wdat;

    // A zero instruction word is a pipeline bubble.
    assign valid  = (wbinstr != '0);
    assign commit = valid && (state == WB_RUN) && !wbcuHALT;

    wb_data_select #(
        .WORD_W(WORD_W)
    ) u_data_select (
        .lui_flag  (wbLUIflag),
        .mem_to_reg(wbMemToReg),
        .alu_result(wbOutput_Port),
        .load_data (wbdmemload),
        .lui_data  (wbLUIdata),
        .wdat      (sel_wdat)
    );

    always_comb begin
        rf_WEN  = commit && wbWEN && (wbwsel != '0);
        rf_wsel = wbwsel;
        rf_wdat = sel_wdat;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= WB_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            WB_RUN:    if (valid && wbcuHALT) state_next = WB_FLUSH;
            WB_FLUSH:  if (dflushed) state_next = WB_HALTED;
            WB_HALTED: state_next = WB_HALTED;
            default:   state_next = WB_RUN;
        endcase
    end

    // Decoded straight from the state flop, so both outputs are glitch-free registered levels.
    always_comb begin
        dflush = (state == WB_FLUSH);
        halt   = (state == WB_HALTED);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fwd_valid <= 1'b0;
            fwd_wsel  <= '0;
            fwd_wdat  <= '0;
        end else begin
            fwd_valid <= rf_WEN;
            if (rf_WEN) begin
                fwd_wsel <= rf_wsel;
                fwd_wdat <= rf_wdat;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            retired <= '0;
        end else if (commit && (retired != '1)) begin
            retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: table-driven commits with a forwarding scoreboard,
// then hand-written halt/flush, async reset and counter saturation sequences.
module tb_writeback_unit;

    logic        CLK;
    logic        nRST;
    logic        wbcuHALT;
    logic        wbMemToReg;
    logic        wbWEN;
    logic        wbLUIflag;
    logic [4:0]  wbwsel;
    logic [31:0] wbOutput_Port;
    logic [31:0] wbdmemload;
    logic [31:0] wbLUIdata;
    logic [31:0] wbinstr;
    logic        dflushed;

    logic        rf_WEN;
    logic [4:0]  rf_wsel;
    logic [31:0] rf_wdat;
    logic        fwd_valid;
    logic [4:0]  fwd_wsel;
    logic [31:0] fwd_wdat;
    logic        dflush;
    logic        halt;
    logic [31:0] retired;

    logic        s_rf_WEN;
    logic [4:0]  s_rf_wsel;
    logic [31:0] s_rf_wdat;
    logic        s_fwd_valid;
    logic [4:0]  s_fwd_wsel;
    logic [31:0] s_fwd_wdat;
    logic        s_dflush;
    logic        s_halt;
    logic [1:0]  s_retired;

    writeback_unit #(
        .WORD_W(32), .REG_SEL_W(5), .CNT_W(32)
    ) dut (
        .CLK(CLK), .nRST(nRST), .wbcuHALT(wbcuHALT), .wbMemToReg(wbMemToReg), .wbWEN(wbWEN),
        .wbLUIflag(wbLUIflag), .wbwsel(wbwsel), .wbOutput_Port(wbOutput_Port),
        .wbdmemload(wbdmemload), .wbLUIdata(wbLUIdata), .wbinstr(wbinstr), .dflushed(dflushed),
        .rf_WEN(rf_WEN), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat), .fwd_valid(fwd_valid),
        .fwd_wsel(fwd_wsel), .fwd_wdat(fwd_wdat), .dflush(dflush), .halt(halt), .retired(retired)
    );

    // Narrow counter instance shares the stimulus to exercise saturation without forcing state.
    writeback_unit #(
        .WORD_W(32), .REG_SEL_W(5), .CNT_W(2)
    ) dut_sat (
        .CLK(CLK), .nRST(nRST), .wbcuHALT(wbcuHALT), .wbMemToReg(wbMemToReg), .wbWEN(wbWEN),
        .wbLUIflag(wbLUIflag), .wbwsel(wbwsel), .wbOutput_Port(wbOutput_Port),
        .wbdmemload(wbdmemload), .wbLUIdata(wbLUIdata), .wbinstr(wbinstr), .dflushed(dflushed),
        .rf_WEN(s_rf_WEN), .rf_wsel(s_rf_wsel), .rf_wdat(s_rf_wdat), .fwd_valid(s_fwd_valid),
        .fwd_wsel(s_fwd_wsel), .fwd_wdat(s_fwd_wdat), .dflush(s_dflush), .halt(s_halt),
        .retired(s_retired)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] instr;
        logic        wen;
        logic        mem_to_reg;
        logic        lui;
        logic [4:0]  wsel;
        logic [31:0] alu;
        logic [31:0] load;
        logic [31:0] luid;
        logic        exp_wen;
        logic [31:0] exp_wdat;
        logic        exp_fv;
        logic [4:0]  exp_fsel;
        logic [31:0] exp_fdat;
        logic [31:0] exp_ret;
        logic [1:0]  exp_sat;
    } vec_t;

    typedef struct {
        logic        fv;
        logic [4:0]  fsel;
        logic [31:0] fdat;
        logic [31:0] ret;
        logic [1:0]  sat;
    } fwd_exp_t;

    vec_t     vecs[7];
    fwd_exp_t sb[$];
    fwd_exp_t e;
    int       total;
    int       bad;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic hlt, input logic wen,
                         input logic [4:0] wsel, input logic [31:0] alu);
        wbinstr       = instr;
        wbcuHALT      = hlt;
        wbWEN         = wen;
        wbwsel        = wsel;
        wbOutput_Port = alu;
        wbMemToReg    = 1'b0;
        wbLUIflag     = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        //          instr     wen mr lui wsel alu           load      luid          ewen ewdat         fv fsel fdat          ret sat
        vecs[0] = '{32'h1,    1, 0, 0, 5'd5,  32'h1234,     32'h0,    32'h0,        1, 32'h1234,     1, 5'd5,  32'h1234,     1, 2'd1};
        vecs[1] = '{32'h2,    1, 1, 1, 5'd7,  32'h0,        32'h55,   32'hABCD0000, 1, 32'hABCD0000, 1, 5'd7,  32'hABCD0000, 2, 2'd2};
        vecs[2] = '{32'h3,    1, 1, 0, 5'd8,  32'h0,        32'h55,   32'hABCD0000, 1, 32'h55,       1, 5'd8,  32'h55,       3, 2'd3};
        vecs[3] = '{32'h4,    1, 0, 0, 5'd0,  32'h99,       32'h0,    32'h0,        0, 32'h99,       0, 5'd8,  32'h55,       4, 2'd3};
        vecs[4] = '{32'h0,    1, 0, 0, 5'd9,  32'h77,       32'h0,    32'h0,        0, 32'h77,       0, 5'd8,  32'h55,       4, 2'd3};
        vecs[5] = '{32'h5,    0, 0, 0, 5'd10, 32'h88,       32'h0,    32'h0,        0, 32'h88,       0, 5'd8,  32'h55,       5, 2'd3};
        vecs[6] = '{32'h6,    1, 0, 0, 5'd31, 32'hFFFFFFFF, 32'h0,    32'h0,        1, 32'hFFFFFFFF, 1, 5'd31, 32'hFFFFFFFF, 6, 2'd3};

        nRST     = 1'b0;
        dflushed = 1'b0;
        wbdmemload = '0;
        wbLUIdata  = '0;
        drive(32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        tick();
        check("reset_fwd_valid", fwd_valid, 0);
        check("reset_fwd_wsel", fwd_wsel, 0);
        check("reset_fwd_wdat", fwd_wdat, 0);
        check("reset_dflush", dflush, 0);
        check("reset_halt", halt, 0);
        check("reset_retired", retired, 0);
        nRST = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            wbinstr       = vecs[i].instr;
            wbcuHALT      = 1'b0;
            wbWEN         = vecs[i].wen;
            wbMemToReg    = vecs[i].mem_to_reg;
            wbLUIflag     = vecs[i].lui;
            wbwsel        = vecs[i].wsel;
            wbOutput_Port = vecs[i].alu;
            wbdmemload    = vecs[i].load;
            wbLUIdata     = vecs[i].luid;
            sb.push_back('{vecs[i].exp_fv, vecs[i].exp_fsel, vecs[i].exp_fdat,
                           vecs[i].exp_ret, vecs[i].exp_sat});
            #1;
            check($sformatf("vec%0d_rf_WEN", i), rf_WEN, vecs[i].exp_wen);
            check($sformatf("vec%0d_rf_wsel", i), rf_wsel, vecs[i].wsel);
            check($sformatf("vec%0d_rf_wdat", i), rf_wdat, vecs[i].exp_wdat);
            tick();
            e = sb.pop_front();
            check($sformatf("vec%0d_fwd_valid", i), fwd_valid, e.fv);
            check($sformatf("vec%0d_fwd_wsel", i), fwd_wsel, e.fsel);
            check($sformatf("vec%0d_fwd_wdat", i), fwd_wdat, e.fdat);
            check($sformatf("vec%0d_retired", i), retired, e.ret);
            check($sformatf("vec%0d_sat_retired", i), s_retired, e.sat);
        end

        // dflushed in RUN must not disturb anything.
        drive(32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        dflushed = 1'b1;
        tick();
        check("run_dflushed_dflush", dflush, 0);
        check("run_dflushed_halt", halt, 0);
        dflushed = 1'b0;

        // Halt instruction with write enable: no write, then flush request.
        drive(32'hFC000000, 1'b1, 1'b1, 5'd3, 32'hDEAD);
        #1;
        check("halt_rf_WEN", rf_WEN, 0);
        tick();
        check("flush_dflush", dflush, 1);
        check("flush_halt", halt, 0);
        check("flush_fwd_valid", fwd_valid, 0);
        check("flush_retired", retired, 6);
        drive(32'h7, 1'b0, 1'b1, 5'd4, 32'h4444);
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("flush_wait%0d_rf_WEN", c), rf_WEN, 0);
            tick();
            check($sformatf("flush_wait%0d_dflush", c), dflush, 1);
            check($sformatf("flush_wait%0d_halt", c), halt, 0);
            check($sformatf("flush_wait%0d_retired", c), retired, 6);
        end
        dflushed = 1'b1;
        tick();
        check("halted_dflush", dflush, 0);
        check("halted_halt", halt, 1);
        dflushed = 1'b0;
        repeat (3) tick();
        check("halted_rf_WEN", rf_WEN, 0);
        check("halted_stay", halt, 1);
        check("halted_retired", retired, 6);
        check("halted_fwd_valid", fwd_valid, 0);

        // Async reset while in FLUSH with a non-zero bypass entry held.
        nRST = 1'b0;
        #2;
        nRST = 1'b1;
        drive(32'h8, 1'b0, 1'b1, 5'd6, 32'h42);
        tick();
        check("rst2_retired_pre", retired, 1);
        check("rst2_fwd_wsel_pre", fwd_wsel, 6);
        drive(32'hFC000000, 1'b1, 1'b0, 5'd0, 32'h0);
        tick();
        check("rst2_in_flush", dflush, 1);
        #2;
        nRST = 1'b0;
        #1;
        check("rst2_dflush", dflush, 0);
        check("rst2_halt", halt, 0);
        check("rst2_retired", retired, 0);
        check("rst2_fwd_valid", fwd_valid, 0);
        check("rst2_fwd_wsel", fwd_wsel, 0);
        check("rst2_fwd_wdat", fwd_wdat, 0);
        check("rst2_sat_retired", s_retired, 0);

        // Narrow counter: five commits must stop at all-ones, never wrap.
        nRST = 1'b1;
        drive(32'h9, 1'b0, 1'b1, 5'd2, 32'h5);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("sat_step%0d", k), s_retired, (k > 3) ? 3 : k);
        end
        check("sat_wide_retired", retired, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
